// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data SRAM access controller: FSM states and
// access-size encodings.
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      RESP = 3'd3,
      DROP = 3'd4
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // The illegal encoding 3 goes onto the bus as a full word.
   function automatic logic [1:0] norm_size(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: return SZ_BYTE;
         SZ_HALF: return SZ_HALF;
         default: return SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/data_sram_ctrl.sv
// Sequences a single outstanding load/store from EX onto the split
// req/addr_ok/data_ok SRAM bus and returns the result to MEM, swallowing flushed ops.
module data_sram_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_wr,
   input  logic [1:0]  ex_size,
   input  logic [3:0]  ex_wstrb,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic        ex_excp,
   input  logic        flush,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [1:0]  data_sram_size,
   output logic [3:0]  data_sram_wstrb,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata
);

   state_e      state_q, state_d;
   logic        kill_q, kill_d;
   logic        req_q, req_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] bus_rsp;

   // Stores complete with zero data so MEM never sees stale read bits.
   assign bus_rsp = wr_q ? 32'd0 : data_sram_rdata;

   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      req_d   = req_q;
      wr_d    = wr_q;
      size_d  = size_q;
      wstrb_d = wstrb_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      buf_d   = buf_q;
      case (state_q)
         IDLE: begin
            if (ex_valid && !ex_excp && !flush) begin
               wr_d    = ex_wr;
               size_d  = norm_size(ex_size);
               wstrb_d = ex_wr ? ex_wstrb : 4'd0;
               addr_d  = ex_addr;
               wdata_d = ex_wdata;
               req_d   = 1'b1;
               kill_d  = 1'b0;
               state_d = REQ;
            end
         end
         REQ: begin
            // The request stays up until addr_ok; a flush only marks it dead.
            if (flush) kill_d = 1'b1;
            if (data_sram_addr_ok) begin
               req_d   = 1'b0;
               kill_d  = 1'b0;
               state_d = (kill_q || flush) ? DROP : WAIT;
            end
         end
         WAIT: begin
            if (data_sram_data_ok) begin
               if (flush || rsp_ready) begin
                  state_d = IDLE;
               end else begin
                  buf_d   = bus_rsp;
                  state_d = RESP;
               end
            end else if (flush) begin
               state_d = DROP;
            end
         end
         RESP: begin
            if (flush || rsp_ready) state_d = IDLE;
         end
         DROP: begin
            if (data_sram_data_ok) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         kill_q  <= 1'b0;
         req_q   <= 1'b0;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         wstrb_q <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         buf_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
         req_q   <= req_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         wstrb_q <= wstrb_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         buf_q   <= buf_d;
      end
   end

   assign ex_ready        = (state_q == IDLE);
   assign data_sram_req   = req_q;
   assign data_sram_wr    = wr_q;
   assign data_sram_size  = size_q;
   assign data_sram_wstrb = wstrb_q;
   assign data_sram_addr  = addr_q;
   assign data_sram_wdata = wdata_q;

   always_comb begin
      rsp_valid = 1'b0;
      rsp_rdata = 32'd0;
      if (!flush) begin
         if (state_q == WAIT && data_sram_data_ok) begin
            rsp_valid = 1'b1;
            rsp_rdata = bus_rsp;
         end else if (state_q == RESP) begin
            rsp_valid = 1'b1;
            rsp_rdata = buf_q;
         end
      end
   end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: inputs change 1ns after each rising
// edge, outputs are checked on the falling edge.
module tb_data_sram_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ex_valid, ex_ready, ex_wr, ex_excp, flush;
   logic [1:0]  ex_size;
   logic [3:0]  ex_wstrb;
   logic [31:0] ex_addr, ex_wdata;
   logic        data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_sram_ctrl dut (
      .clk(clk), .resetn(resetn),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wr(ex_wr), .ex_size(ex_size),
      .ex_wstrb(ex_wstrb), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_excp(ex_excp),
      .flush(flush),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] addr);
      cyc();
      ex_valid = 1'b1; ex_wr = wr; ex_size = sz; ex_addr = addr;
   endtask

   initial begin
      resetn = 1'b0; ex_valid = 0; ex_wr = 0; ex_size = 0; ex_wstrb = 0;
      ex_addr = 0; ex_wdata = 0; ex_excp = 0; flush = 0;
      data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0; rsp_ready = 0;

      // Reset state
      cyc(); cyc();
      mid();
      chk("rst_req", {31'd0, data_sram_req}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_addr", data_sram_addr, 32'd0);
      cyc(); resetn = 1'b1;
      mid();
      chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);

      // Load word, immediate addr_ok, data_ok next cycle
      issue(1'b0, 2'd2, 32'h0000_1004); rsp_ready = 1'b1;
      cyc(); ex_valid = 0; data_sram_addr_ok = 1;
      mid();
      chk("lw_req", {31'd0, data_sram_req}, 32'd1);
      chk("lw_addr", data_sram_addr, 32'h0000_1004);
      chk("lw_size", {30'd0, data_sram_size}, 32'd2);
      chk("lw_wr", {31'd0, data_sram_wr}, 32'd0);
      chk("lw_ex_ready_busy", {31'd0, ex_ready}, 32'd0);
      cyc(); data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_BEEF;
      mid();
      chk("lw_req_drop", {31'd0, data_sram_req}, 32'd0);
      chk("lw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("lw_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      cyc(); data_sram_data_ok = 0;
      mid();
      chk("lw_rsp_once", {31'd0, rsp_valid}, 32'd0);
      chk("lw_ex_ready_back", {31'd0, ex_ready}, 32'd1);

      // Store byte with addr_ok delayed three cycles
      issue(1'b1, 2'd0, 32'h0000_2002); ex_wstrb = 4'b0100; ex_wdata = 32'h00AB_0000;
      cyc(); ex_valid = 0; ex_wdata = 32'h1111_1111; ex_addr = 32'h9999_9999; ex_wstrb = 4'hF;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) data_sram_addr_ok = 1;
         mid();
         chk("sb_req_held", {31'd0, data_sram_req}, 32'd1);
         chk("sb_addr_held", data_sram_addr, 32'h0000_2002);
         chk("sb_wdata_held", data_sram_wdata, 32'h00AB_0000);
         chk("sb_bus_ctl", {25'd0, data_sram_wr, data_sram_size, data_sram_wstrb}, {25'd0, 1'b1, 2'd0, 4'b0100});
         if (i < 3) cyc();
      end
      cyc(); data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hFFFF_FFFF;
      mid();
      chk("sb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("sb_rsp_zero", rsp_rdata, 32'd0);
      cyc(); data_sram_data_ok = 0;
      mid();
      chk("sb_ex_ready", {31'd0, ex_ready}, 32'd1);

      // Exception op: consumed, no request
      issue(1'b0, 2'd2, 32'h0000_5000); ex_excp = 1;
      mid();
      chk("excp_ex_ready", {31'd0, ex_ready}, 32'd1);
      cyc(); ex_valid = 0; ex_excp = 0;
      mid();
      chk("excp_no_req", {31'd0, data_sram_req}, 32'd0);
      cyc();
      mid();
      chk("excp_no_req2", {31'd0, data_sram_req}, 32'd0);
      chk("excp_idle", {31'd0, ex_ready}, 32'd1);

      // Flush during REQ (illegal size 3 also checked)
      issue(1'b0, 2'd3, 32'h0000_3000);
      cyc(); ex_valid = 0; flush = 1;
      mid();
      chk("fl_req", {31'd0, data_sram_req}, 32'd1);
      chk("fl_size3_word", {30'd0, data_sram_size}, 32'd2);
      cyc(); flush = 0;
      mid();
      chk("fl_req_kept", {31'd0, data_sram_req}, 32'd1);
      cyc(); data_sram_addr_ok = 1;
      mid();
      chk("fl_req_at_aok", {31'd0, data_sram_req}, 32'd1);
      cyc(); data_sram_addr_ok = 0;
      mid();
      chk("fl_drop_req", {31'd0, data_sram_req}, 32'd0);
      chk("fl_drop_busy", {31'd0, ex_ready}, 32'd0);
      cyc(); data_sram_data_ok = 1; data_sram_rdata = 32'h1234_5678;
      mid();
      chk("fl_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("fl_busy_dok", {31'd0, ex_ready}, 32'd0);
      cyc(); data_sram_data_ok = 0;
      mid();
      chk("fl_no_rsp_after", {31'd0, rsp_valid}, 32'd0);
      chk("fl_ex_ready", {31'd0, ex_ready}, 32'd1);

      // Backpressure: RESP holds data until rsp_ready
      issue(1'b0, 2'd2, 32'h0000_4000); rsp_ready = 0;
      cyc(); ex_valid = 0; data_sram_addr_ok = 1;
      cyc(); data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hCAFE_F00D;
      mid();
      chk("bp_rsp_wait", rsp_rdata, 32'hCAFE_F00D);
      for (int i = 0; i < 2; i++) begin
         cyc(); data_sram_data_ok = 0; data_sram_rdata = 32'h0BAD_0BAD;
         mid();
         chk("bp_resp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_resp_stable", rsp_rdata, 32'hCAFE_F00D);
      end
      cyc(); rsp_ready = 1;
      mid();
      chk("bp_xfer", {31'd0, rsp_valid}, 32'd1);
      cyc(); rsp_ready = 0;
      mid();
      chk("bp_one_xfer", {31'd0, rsp_valid}, 32'd0);
      chk("bp_idle", {31'd0, ex_ready}, 32'd1);

      // Flush while in RESP
      issue(1'b0, 2'd2, 32'h0000_4004);
      cyc(); ex_valid = 0; data_sram_addr_ok = 1;
      cyc(); data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h55AA_55AA;
      cyc(); data_sram_data_ok = 0;
      mid();
      chk("fr_resp", rsp_rdata, 32'h55AA_55AA);
      cyc(); flush = 1;
      mid();
      chk("fr_killed", {31'd0, rsp_valid}, 32'd0);
      cyc(); flush = 0;
      mid();
      chk("fr_idle", {31'd0, ex_ready}, 32'd1);
      chk("fr_no_rsp", {31'd0, rsp_valid}, 32'd0);

      // Flush coincident with data_ok in WAIT
      issue(1'b0, 2'd2, 32'h0000_4008); rsp_ready = 1;
      cyc(); ex_valid = 0; data_sram_addr_ok = 1;
      cyc(); data_sram_addr_ok = 0; data_sram_data_ok = 1; flush = 1;
      mid();
      chk("fw_suppressed", {31'd0, rsp_valid}, 32'd0);
      cyc(); data_sram_data_ok = 0; flush = 0;
      mid();
      chk("fw_idle", {31'd0, ex_ready}, 32'd1);

      // Reset while in WAIT
      issue(1'b1, 2'd2, 32'h0000_6000); ex_wstrb = 4'hF; ex_wdata = 32'h7777_7777;
      cyc(); ex_valid = 0; data_sram_addr_ok = 1;
      cyc(); data_sram_addr_ok = 0;
      mid();
      chk("rw_in_wait", {31'd0, ex_ready}, 32'd0);
      cyc(); resetn = 0;
      cyc(); resetn = 1;
      mid();
      chk("rw_req", {31'd0, data_sram_req}, 32'd0);
      chk("rw_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("rw_ex_ready", {31'd0, ex_ready}, 32'd1);
      chk("rw_bus_clr", data_sram_wdata, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
